tenthirty_ctrl: RTL

Round sequencer for the ten-and-a-half card game. It requests cards from the deck LUT one at a time via a single-cycle `pip` and captures the card `number` returned the next cycle. It accumulates player and dealer scores in half-points, runs the player hit/stay phase and the fixed dealer policy, and reports the round result. It sits between the button/debounce front end and the display/score logic.

---
 rtl/tenthirty_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/tenthirty_ctrl.sv
// tenthirty_ctrl: round sequencer for the ten-and-a-half card game.
//   clk, rst_n              clock, asynchronous active-low reset
//   start, hit, stay        one-cycle command pulses from the button front end
//   number                  card from the deck LUT, valid the cycle after pip (0 = deck empty)
//   pip                     registered one-cycle card request to the LUT
//   player_pts, dealer_pts  hand scores in half-points
//   player_cnt, dealer_cnt  cards held per hand
//   turn                    waiting for player hit/stay
//   done, result            round finished; 0 none, 1 player, 2 dealer, 3 tie, 4 abort
module tenthirty_ctrl #(
    parameter int MAX_CARDS    = 5,
    parameter int DEALER_STAND = 14,
    parameter int BUST_LIMIT   = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    input  logic       stay,
    input  logic [3:0] number,
    output logic       pip,
    output logic [5:0] player_pts,
    output logic [5:0] dealer_pts,
    output logic [2:0] player_cnt,
    output logic [2:0] dealer_cnt,
    output logic       turn,
    output logic       done,
    output logic [2:0] result
);
    typedef enum logic [3:0] {
        IDLE, P0_REQ, P0_CAP, D0_REQ, D0_CAP, PLAYER, PH_REQ, PH_CAP,
        DLR, DH_REQ, DH_CAP, JUDGE, DONE
    } state_t;
    localparam logic [5:0] BUST  = 6'(BUST_LIMIT);
    localparam logic [5:0] STAND = 6'(DEALER_STAND);
    localparam logic [2:0] MAXC  = 3'(MAX_CARDS);
    localparam logic [2:0] R_NONE = 3'd0, R_PLAYER = 3'd1, R_DEALER = 3'd2, R_TIE = 3'd3, R_ABORT = 3'd4;
    state_t     state_q, state_d;
    logic       pip_q, pip_d;
    logic [5:0] ppts_q, ppts_d, dpts_q, dpts_d, card_v, ppts_sum, dpts_sum;
    logic [2:0] pcnt_q, pcnt_d, dcnt_q, dcnt_d, pcnt_inc, dcnt_inc;
    logic [2:0] result_q, result_d, verdict_q, verdict_d;
    logic       cap_empty;
    // Face cards are worth half a point; number cards their face value.
    assign card_v    = number == 4'd0 ? 6'd0 : number <= 4'd10 ? {1'b0, number, 1'b0} : 6'd1;
    assign ppts_sum  = ppts_q + card_v;
    assign dpts_sum  = dpts_q + card_v;
    assign pcnt_inc  = pcnt_q + 3'd1;
    assign dcnt_inc  = dcnt_q + 3'd1;
    assign cap_empty = (state_q inside {P0_CAP, D0_CAP, PH_CAP, DH_CAP}) && number == 4'd0;
    always_comb begin
        state_d   = state_q;
        ppts_d    = ppts_q;
        dpts_d    = dpts_q;
        pcnt_d    = pcnt_q;
        dcnt_d    = dcnt_q;
        result_d  = result_q;
        verdict_d = verdict_q;
        if (cap_empty) begin
            state_d  = DONE;
            result_d = R_ABORT;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_d   = P0_REQ;
                    ppts_d    = 6'd0;
                    dpts_d    = 6'd0;
                    pcnt_d    = 3'd0;
                    dcnt_d    = 3'd0;
                    result_d  = R_NONE;
                    verdict_d = R_NONE;
                end
                P0_REQ: state_d = P0_CAP;
                P0_CAP: begin
                    ppts_d  = ppts_sum;
                    pcnt_d  = pcnt_inc;
                    state_d = D0_REQ;
                end
                D0_REQ: state_d = D0_CAP;
                D0_CAP: begin
                    dpts_d  = dpts_sum;
                    dcnt_d  = dcnt_inc;
                    state_d = PLAYER;
                end
                PLAYER: state_d = stay ? DLR : hit ? PH_REQ : PLAYER;
                PH_REQ: state_d = PH_CAP;
                PH_CAP: begin
                    ppts_d    = ppts_sum;
                    pcnt_d    = pcnt_inc;
                    state_d   = (ppts_sum > BUST || pcnt_inc == MAXC) ? JUDGE : PLAYER;
                    verdict_d = ppts_sum > BUST ? R_DEALER : pcnt_inc == MAXC ? R_PLAYER : R_NONE;
                end
                DLR: state_d = (dpts_q < STAND && dcnt_q < MAXC) ? DH_REQ : JUDGE;
                DH_REQ: state_d = DH_CAP;
                DH_CAP: begin
                    dpts_d    = dpts_sum;
                    dcnt_d    = dcnt_inc;
                    state_d   = dpts_sum > BUST ? JUDGE : DLR;
                    verdict_d = dpts_sum > BUST ? R_PLAYER : R_NONE;
                end
                // A verdict left by a bust or a full hand overrides the score compare.
                JUDGE: begin
                    state_d  = DONE;
                    result_d = verdict_q != R_NONE ? verdict_q :
                               ppts_q > dpts_q ? R_PLAYER : ppts_q < dpts_q ? R_DEALER : R_TIE;
                end
                default: state_d = IDLE;
            endcase
        end
        // Every REQ is followed by a CAP, so pip can never be high two cycles running.
        pip_d = state_d inside {P0_REQ, D0_REQ, PH_REQ, DH_REQ};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pip_q     <= 1'b0;
            ppts_q    <= 6'd0;
            dpts_q    <= 6'd0;
            pcnt_q    <= 3'd0;
            dcnt_q    <= 3'd0;
            result_q  <= R_NONE;
            verdict_q <= R_NONE;
        end else begin
            state_q   <= state_d;
            pip_q     <= pip_d;
            ppts_q    <= ppts_d;
            dpts_q    <= dpts_d;
            pcnt_q    <= pcnt_d;
            dcnt_q    <= dcnt_d;
            result_q  <= result_d;
            verdict_q <= verdict_d;
        end
    end
    assign pip        = pip_q;
    assign player_pts = ppts_q;
    assign dealer_pts = dpts_q;
    assign player_cnt = pcnt_q;
    assign dealer_cnt = dcnt_q;
    assign turn       = state_q == PLAYER;
    assign done       = state_q == DONE;
    assign result     = result_q;
endmodule
